// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB controller with req/ack memory ports.
// Define DEBUG_REGS_EN to expose registers $8, $16..$19 on debug_Reg* output ports.
module multicycle_core #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       Instruction,
  output logic [CNT_W-1:0]  retired,
  output logic              illegal
`ifdef DEBUG_REGS_EN
  ,
  (* mark_debug = "true" *) output logic [31:0] debug_Reg8,
  (* mark_debug = "true" *) output logic [31:0] debug_Reg16,
  (* mark_debug = "true" *) output logic [31:0] debug_Reg17,
  (* mark_debug = "true" *) output logic [31:0] debug_Reg18,
  (* mark_debug = "true" *) output logic [31:0] debug_Reg19
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [ADDR_W-1:0] J_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;

  logic [31:0] regs_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rs, rf_rt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] imm_sext;
  logic [31:0] alu_res;
  logic        is_legal;
  logic        branch_taken;
  logic [ADDR_W-1:0] br_target, j_target;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign imm26    = ir_q[25:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};

  assign rf_rs = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rf_rt = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  // pc_q already holds PC+4 once the instruction has been fetched.
  assign br_target    = pc_q + ADDR_W'($signed({imm16, 2'b00}));
  assign j_target     = (pc_q & ~J_MASK) | ADDR_W'({imm26, 2'b00});
  assign branch_taken = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  always_comb begin
    is_legal = 1'b0;
    alu_res  = 32'd0;
    case (opcode)
      OP_RTYPE: begin
        is_legal = 1'b1;
        case (funct)
          F_ADD:   alu_res = a_q + b_q;
          F_SUB:   alu_res = a_q - b_q;
          F_AND:   alu_res = a_q & b_q;
          F_OR:    alu_res = a_q | b_q;
          F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
          F_SLL:   alu_res = b_q << shamt;
          F_SRL:   alu_res = b_q >> shamt;
          default: is_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        is_legal = 1'b1;
        alu_res  = a_q + imm_sext;
      end
      OP_BEQ, OP_BNE, OP_J: is_legal = 1'b1;
      default:              is_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'd0;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rs;
        b_d     = rf_rt;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = alu_res;
        state_d = S_FETCH;
        if (!is_legal) begin
          illegal_d = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end else begin
          case (opcode)
            OP_BEQ, OP_BNE: begin
              if (branch_taken) pc_d = br_target;
              retired_d = retired_q + CNT_W'(1);
            end
            OP_J: begin
              pc_d      = j_target;
              retired_d = retired_q + CNT_W'(1);
            end
            OP_LW, OP_SW: state_d = S_MEM;
            default:      state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (opcode == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata  = (opcode == OP_LW) ? mdr_q : alu_q;
        instr_d   = rf_wdata;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Requests are registered and raised on the edge entering FETCH/MEM, so a zero-wait
  // memory can ack in the very first cycle of the state.
  always_comb begin
    imem_req_d   = (state_d == S_FETCH);
    imem_addr_d  = imem_req_d ? pc_d : imem_addr_q;
    dmem_req_d   = (state_d == S_MEM);
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = 1'b0;
    if (state_q == S_EXEC && state_d == S_MEM) begin
      dmem_addr_d  = ADDR_W'(alu_res);
      dmem_wdata_d = b_q;
      dmem_we_d    = (opcode == OP_SW);
    end else if (state_q == S_MEM && state_d == S_MEM) begin
      dmem_we_d = dmem_we_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      instr_q      <= '0;
      retired_q    <= '0;
      illegal_q    <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_q        <= alu_d;
      mdr_q        <= mdr_d;
      instr_q      <= instr_d;
      retired_q    <= retired_d;
      illegal_q    <= illegal_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign Instruction = instr_q;
  assign retired     = retired_q;
  assign illegal     = illegal_q;

`ifdef DEBUG_REGS_EN
  assign debug_Reg8  = regs_q[8];
  assign debug_Reg16 = regs_q[16];
  assign debug_Reg17 = regs_q[17];
  assign debug_Reg18 = regs_q[18];
  assign debug_Reg19 = regs_q[19];
`endif

endmodule
